// File: rtl/contra_vga_timing.sv
// VGA raster timing generator: pixel/line counters plus registered hs, vs, blank and frame_end.
// Optional macro CONTRA_VGA_SYNC_DELAY_EN delays hs/vs/blank by two vga_clk cycles to match the mapper pipeline.
module contra_vga_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_end
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] x_next;
    logic [9:0] y_next;
    logic       hs_base;
    logic       vs_base;
    logic       blank_base;

    always_comb begin
        x_next = DrawX + 10'd1;
        y_next = DrawY;
        if (DrawX == H_LAST) begin
            x_next = '0;
            y_next = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
        end
    end

    // Decode from the next counter values so the registered flags line up with DrawX/DrawY.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            DrawX      <= '0;
            DrawY      <= '0;
            hs_base    <= 1'b1;
            vs_base    <= 1'b1;
            blank_base <= 1'b1;
            frame_end  <= 1'b0;
        end else begin
            DrawX      <= x_next;
            DrawY      <= y_next;
            hs_base    <= ~((x_next >= HS_START) && (x_next < HS_END));
            vs_base    <= ~((y_next >= VS_START) && (y_next < VS_END));
            blank_base <= (x_next < H_VIS) && (y_next < V_VIS);
            frame_end  <= (x_next == H_LAST) && (y_next == V_LAST);
        end
    end

`ifdef CONTRA_VGA_SYNC_DELAY_EN
    logic [1:0] hs_pipe;
    logic [1:0] vs_pipe;
    logic [1:0] blank_pipe;

    // Two-stage delay so sync and blank arrive with the mapper's pixel data.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hs_pipe    <= 2'b11;
            vs_pipe    <= 2'b11;
            blank_pipe <= 2'b00;
        end else begin
            hs_pipe    <= {hs_pipe[0], hs_base};
            vs_pipe    <= {vs_pipe[0], vs_base};
            blank_pipe <= {blank_pipe[0], blank_base};
        end
    end

    assign hs    = hs_pipe[1];
    assign vs    = vs_pipe[1];
    assign blank = blank_pipe[1];
`else
    assign hs    = hs_base;
    assign vs    = vs_base;
    assign blank = blank_base;
`endif

endmodule

// File: tb/tb_contra_vga_timing.sv
// Self-checking bench for contra_vga_timing: a small-geometry instance and a default-geometry instance
// compared every cycle against an arithmetic raster model, with randomized run lengths and reset pulses.
module tb_contra_vga_timing;

`ifdef CONTRA_VGA_SYNC_DELAY_EN
    localparam int D = 2;
    localparam logic BLANK_RST = 1'b0;
`else
    localparam int D = 0;
    localparam logic BLANK_RST = 1'b1;
`endif

    // Small geometry: 29 pixels x 17 lines = 493 cycles per frame.
    localparam int SHV = 16, SHF = 4, SHS = 6, SHB = 3;
    localparam int SVV = 10, SVF = 2, SVS = 2, SVB = 3;
    localparam int SHT = SHV + SHF + SHS + SHB;
    localparam int SVT = SVV + SVF + SVS + SVB;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       fe;
    } obs_t;

    logic       vga_clk = 1'b0;
    logic       reset   = 1'b1;
    logic [9:0] s_x, s_y, d_x, d_y;
    logic       s_hs, s_vs, s_blank, s_fe;
    logic       d_hs, d_vs, d_blank, d_fe;
    obs_t       got_s, got_d, exp_v;
    int         n = 0;
    int         compared = 0;
    int         mismatched = 0;

    always #5 vga_clk = ~vga_clk;

    contra_vga_timing #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
    ) dut_small (
        .vga_clk(vga_clk), .reset(reset), .DrawX(s_x), .DrawY(s_y),
        .hs(s_hs), .vs(s_vs), .blank(s_blank), .frame_end(s_fe)
    );

    contra_vga_timing dut_def (
        .vga_clk(vga_clk), .reset(reset), .DrawX(d_x), .DrawY(d_y),
        .hs(d_hs), .vs(d_vs), .blank(d_blank), .frame_end(d_fe)
    );

    assign got_s = '{x: s_x, y: s_y, hs: s_hs, vs: s_vs, blank: s_blank, fe: s_fe};
    assign got_d = '{x: d_x, y: d_y, hs: d_hs, vs: d_vs, blank: d_blank, fe: d_fe};

    // Cycles elapsed since the last reset edge; the model derives everything from this.
    always @(posedge vga_clk) begin
        if (reset) n <= 0;
        else       n <= n + 1;
    end

    function automatic obs_t model(int cyc, int hv, int hf, int hsw, int hb,
                                   int vv, int vf, int vsw, int vb);
        obs_t e;
        int ht, vt, xi, yi, m, xm, ym;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        xi = cyc % ht;
        yi = (cyc / ht) % vt;
        e.x  = 10'(xi);
        e.y  = 10'(yi);
        e.fe = (xi == ht - 1) && (yi == vt - 1);
        m = cyc - D;
        if (m < 0) begin
            e.hs = 1'b1; e.vs = 1'b1; e.blank = 1'b0;
        end else begin
            xm = m % ht;
            ym = (m / ht) % vt;
            e.hs    = !(xm >= hv + hf && xm < hv + hf + hsw);
            e.vs    = !(ym >= vv + vf && ym < vv + vf + vsw);
            e.blank = (xm < hv) && (ym < vv);
        end
        return e;
    endfunction

    function automatic obs_t model_s(int cyc);
        return model(cyc, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
    endfunction

    function automatic obs_t model_d(int cyc);
        return model(cyc, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    task automatic test_reset();
        exp_v = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, blank: BLANK_RST, fe: 1'b0};
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge vga_clk);
            compared++;
            if (got_s !== exp_v) begin
                mismatched++;
                $display("[TB] FAIL reset_small cycle %0d: got %h required %h", i, got_s, exp_v);
            end
            compared++;
            if (got_d !== exp_v) begin
                mismatched++;
                $display("[TB] FAIL reset_def cycle %0d: got %h required %h", i, got_d, exp_v);
            end
        end
        reset = 1'b0;
        @(negedge vga_clk);
        compared++;
        if (s_x !== 10'd1 || s_y !== 10'd0) begin
            mismatched++;
            $display("[TB] FAIL first_free_edge: got x=%0d y=%0d required x=1 y=0", s_x, s_y);
        end
    endtask

    task automatic test_line();
        int hs_fall, hs_rise, bl_fall, bl_rise, hs_low;
        logic prev_hs, prev_bl;
        hs_fall = -1; hs_rise = -1; bl_fall = -1; bl_rise = -1; hs_low = 0;
        reset = 1'b1;
        @(negedge vga_clk);
        reset = 1'b0;
        prev_hs = d_hs;
        prev_bl = d_blank;
        for (int i = 0; i < 810; i++) begin
            @(negedge vga_clk);
            compared++;
            if (got_d !== model_d(n)) begin
                mismatched++;
                $display("[TB] FAIL line_def n=%0d: got %h required %h", n, got_d, model_d(n));
            end
            if (!d_hs) hs_low++;
            if (prev_hs && !d_hs && hs_fall < 0) hs_fall = int'(d_x);
            if (!prev_hs && d_hs && hs_fall >= 0 && hs_rise < 0) hs_rise = int'(d_x);
            if (prev_bl && !d_blank && bl_fall < 0) bl_fall = int'(d_x);
            if (!prev_bl && d_blank && bl_fall >= 0 && bl_rise < 0) bl_rise = int'(d_x);
            prev_hs = d_hs;
            prev_bl = d_blank;
        end
        compared++;
        if (hs_fall != 656 + D) begin
            mismatched++;
            $display("[TB] FAIL hs_fall_x: got %0d required %0d", hs_fall, 656 + D);
        end
        compared++;
        if (hs_rise != 752 + D) begin
            mismatched++;
            $display("[TB] FAIL hs_rise_x: got %0d required %0d", hs_rise, 752 + D);
        end
        compared++;
        if (hs_low != 96) begin
            mismatched++;
            $display("[TB] FAIL hs_low_width: got %0d required 96", hs_low);
        end
        compared++;
        if (bl_fall != 640 + D) begin
            mismatched++;
            $display("[TB] FAIL blank_fall_x: got %0d required %0d", bl_fall, 640 + D);
        end
        compared++;
        if (bl_rise != D) begin
            mismatched++;
            $display("[TB] FAIL blank_rise_x: got %0d required %0d", bl_rise, D);
        end
    endtask

    task automatic test_frame();
        int pulses, vs_low;
        pulses = 0; vs_low = 0;
        reset = 1'b1;
        @(negedge vga_clk);
        reset = 1'b0;
        for (int i = 0; i < 2 * SHT * SVT + 3; i++) begin
            @(negedge vga_clk);
            compared++;
            if (got_s !== model_s(n)) begin
                mismatched++;
                $display("[TB] FAIL frame_small n=%0d: got %h required %h", n, got_s, model_s(n));
            end
            if (s_fe) begin
                pulses++;
                compared++;
                if (s_x !== 10'(SHT - 1) || s_y !== 10'(SVT - 1)) begin
                    mismatched++;
                    $display("[TB] FAIL frame_end_pos: got x=%0d y=%0d required x=%0d y=%0d",
                             s_x, s_y, SHT - 1, SVT - 1);
                end
            end
            if (n < SHT * SVT && !s_vs) vs_low++;
        end
        compared++;
        if (pulses != 2) begin
            mismatched++;
            $display("[TB] FAIL frame_end_count: got %0d required 2", pulses);
        end
        compared++;
        if (vs_low != SVS * SHT) begin
            mismatched++;
            $display("[TB] FAIL vs_low_cycles: got %0d required %0d", vs_low, SVS * SHT);
        end
    endtask

    task automatic test_reset_mid_sync();
        int target;
        target = (SVV + SVF + 1) * SHT + (SHV + SHF + 2);
        reset = 1'b1;
        @(negedge vga_clk);
        reset = 1'b0;
        for (int i = 0; i < target; i++) begin
            @(negedge vga_clk);
            compared++;
            if (got_s !== model_s(n)) begin
                mismatched++;
                $display("[TB] FAIL mid_run_small n=%0d: got %h required %h", n, got_s, model_s(n));
            end
        end
        compared++;
        if (s_hs !== 1'b0 || s_vs !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL in_sync_before_reset: got hs=%b vs=%b required hs=0 vs=0", s_hs, s_vs);
        end
        reset = 1'b1;
        @(negedge vga_clk);
        exp_v = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, blank: BLANK_RST, fe: 1'b0};
        compared++;
        if (got_s !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL abort_in_sync: got %h required %h", got_s, exp_v);
        end
        reset = 1'b0;
    endtask

    task automatic test_random_resets();
        int len, hold;
        for (int k = 0; k < 6; k++) begin
            len  = $urandom_range(700, 50);
            hold = $urandom_range(3, 1);
            for (int i = 0; i < len; i++) begin
                @(negedge vga_clk);
                compared++;
                if (got_s !== model_s(n)) begin
                    mismatched++;
                    $display("[TB] FAIL random_small k=%0d n=%0d: got %h required %h", k, n, got_s, model_s(n));
                end
                compared++;
                if (got_d !== model_d(n)) begin
                    mismatched++;
                    $display("[TB] FAIL random_def k=%0d n=%0d: got %h required %h", k, n, got_d, model_d(n));
                end
            end
            reset = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge vga_clk);
                compared++;
                if (got_s !== model_s(0)) begin
                    mismatched++;
                    $display("[TB] FAIL random_reset_small k=%0d: got %h required %h", k, got_s, model_s(0));
                end
            end
            reset = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_reset_mid_sync();
        test_random_resets();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/contra_vga_timing.md
CONTRA_VGA_TIMING -- requirements
Module: contra_vga_timing

Interface
REQ-001 Parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 Parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_VISIBLE, default 480, active lines per frame.
REQ-006 Parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 vga_clk  input  1  pixel clock; the block's only clock; all state updates on its rising edge.
REQ-010 reset  input  1  synchronous, active-high reset.
REQ-011 DrawX  output  10  current horizontal counter, 0..H_TOTAL-1.
REQ-012 DrawY  output  10  current vertical counter, 0..V_TOTAL-1.
REQ-013 hs  output  1  horizontal sync, active-low.
REQ-014 vs  output  1  vertical sync, active-low.
REQ-015 blank  output  1  display enable, 1 = visible pixel; feeds the sprite mapper's blank input.
REQ-016 frame_end  output  1  one-cycle pulse on the last pixel of each frame.

Function
REQ-017 H_TOTAL SHALL be the sum of the four H parameters (default 800); V_TOTAL SHALL be the sum of the four V parameters (default 525).
REQ-018 DrawX SHALL increment by 1 each cycle and wrap from H_TOTAL-1 to 0.
REQ-019 DrawY SHALL increment by 1 only on the cycle DrawX wraps, and wrap from V_TOTAL-1 to 0 when DrawX also wraps.
REQ-020 hs SHALL be 0 exactly when H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (default 656..751), else 1.
REQ-021 vs SHALL be 0 exactly when V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (default 490..491), else 1.
REQ-022 blank SHALL be 1 exactly when DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-023 frame_end SHALL be 1 exactly when DrawX = H_TOTAL-1 and DrawY = V_TOTAL-1.
REQ-024 hs, vs, blank and frame_end SHALL be registered outputs, computed from next-state counter values, so they are cycle-aligned with DrawX/DrawY; no combinational path from counters to these outputs.
REQ-025 Frame period SHALL be exactly H_TOTAL*V_TOTAL cycles (default 420000).

Reset
REQ-026 While reset is high at a rising edge, the block SHALL load DrawX=0, DrawY=0, hs=1, vs=1, blank=1, frame_end=0.
REQ-027 On the first edge with reset low, DrawX SHALL become 1 with DrawY=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame immediately with no partial sync pulse continuation; frame_end SHALL not pulse for the aborted frame.

Configuration
REQ-029 Macro CONTRA_VGA_SYNC_DELAY_EN, when defined, SHALL delay hs, vs and blank by 2 additional vga_clk cycles, matching the mapper's ROM-read plus output-register latency; DrawX, DrawY and frame_end remain undelayed.
REQ-030 With CONTRA_VGA_SYNC_DELAY_EN defined, the delay stages SHALL reset to hs=1, vs=1, blank=0; blank, hs and vs then follow REQ-020..022 two cycles late.
REQ-031 Without the macro, no delay registers SHALL exist and REQ-020..022 apply with zero offset.

Verification
REQ-032 Hold reset 3 cycles -> DrawX=0, DrawY=0, hs=1, vs=1, blank=1, frame_end=0 throughout; first free edge gives DrawX=1.
REQ-033 Run one line -> hs falls when DrawX=656, rises when DrawX=752 (96 cycles low); blank falls at DrawX=640, rises at DrawX=0 of the next visible line.
REQ-034 Run one frame -> vs low exactly for DrawY=490..491 (1600 cycles); blank=0 for all DrawY>=480.
REQ-035 Run two frames -> frame_end pulses once per 420000 cycles, at DrawX=799, DrawY=524; next cycle DrawX=0, DrawY=0.
REQ-036 Assert reset at DrawX=700, DrawY=491 (hs and vs low) -> next cycle hs=1, vs=1, DrawX=0, DrawY=0; no frame_end.
REQ-037 With CONTRA_VGA_SYNC_DELAY_EN -> hs falls when DrawX=658, blank falls when DrawX=642; DrawX/DrawY timing unchanged.
